// File: rtl/shift_reg_bank.sv
// Multi-channel tap shift register for the convolution datapath.
// Each of C channels holds an N-tap line that shifts up, down or
// centre-outward one sample per accepted beat, with fill tracking
// that flags when the whole window holds fresh data.
module shift_reg_bank #(
  parameter int N = 11,
  parameter int B = 8,
  parameter int C = 3
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clr,
  input  logic [1:0]                   mode,
  input  logic [C-1:0]                 ch_en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [C-1:0][B-1:0]          din,
  input  logic                         out_stall,
  output logic [C-1:0][N-1:0][B-1:0]   dout,
  output logic                         win_valid,
  output logic [$clog2(N+1)-1:0]       fill_cnt
);

  localparam int M  = N / 2;
  localparam int FW = $clog2(N + 1);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_CENTRE = 2'b11
  } mode_t;

  localparam logic [FW:0]   TGT_LINEAR = (FW+1)'(N);
  localparam logic [FW:0]   TGT_CENTRE = (FW+1)'(N - M);
  localparam logic [FW-1:0] FILL_FULL  = FW'(N);

  // Saturating fill step: centre mode counts as full once the centre tap's
  // data has propagated to both edges (N-M beats), then reports N.
  function automatic logic [FW-1:0] fill_step(input logic [FW-1:0] base,
                                               input mode_t        md);
    logic [FW:0] inc;
    logic [FW:0] tgt;
    inc = {1'b0, base} + (FW+1)'(1);
    tgt = (md == MODE_CENTRE) ? TGT_CENTRE : TGT_LINEAR;
    if (inc >= tgt) fill_step = FILL_FULL;
    else            fill_step = inc[FW-1:0];
  endfunction

  mode_t                       mode_in;
  mode_t                       last_mode_p1;
  logic                        accept;
  logic [FW-1:0]               fill_nxt;
  logic [C-1:0][N-1:0][B-1:0]  taps_nxt;
  logic [C-1:0][N-1:0][B-1:0]  taps_p1;
  logic [FW-1:0]               fill_p1;
  logic                        win_vld_p1;

  assign mode_in  = mode_t'(mode);
  assign in_ready = ~(win_vld_p1 & out_stall);
  assign accept   = in_valid & in_ready & (mode_in != MODE_HOLD);

  // Next fill count: restart at one beat whenever the shift direction changes.
  always_comb begin
    fill_nxt = fill_step((mode_in == last_mode_p1) ? fill_p1 : '0, mode_in);
  end

  // Next tap contents per channel for the requested shift direction.
  always_comb begin
    taps_nxt = taps_p1;
    for (int c = 0; c < C; c++) begin
      if (ch_en[c]) begin
        case (mode_in)
          MODE_UP: begin
            taps_nxt[c][0] = din[c];
            for (int i = 1; i < N; i++) taps_nxt[c][i] = taps_p1[c][i-1];
          end
          MODE_DOWN: begin
            for (int i = 0; i < N-1; i++) taps_nxt[c][i] = taps_p1[c][i+1];
            taps_nxt[c][N-1] = din[c];
          end
          MODE_CENTRE: begin
            for (int i = 0; i < M; i++) taps_nxt[c][i] = taps_p1[c][i+1];
            taps_nxt[c][M] = din[c];
            for (int i = M+1; i < N; i++) taps_nxt[c][i] = taps_p1[c][i-1];
          end
          default: ;
        endcase
      end
    end
  end

  // ---- stage p1: tap registers ----
  // Tap storage: cleared by reset or clr, loaded on accepted beats.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       taps_p1 <= '0;
    else if (clr)    taps_p1 <= '0;
    else if (accept) taps_p1 <= taps_nxt;
  end

  // Fill state, window flag and last direction; clr keeps the direction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fill_p1      <= '0;
      win_vld_p1   <= 1'b0;
      last_mode_p1 <= MODE_UP;
    end else if (clr) begin
      fill_p1    <= '0;
      win_vld_p1 <= 1'b0;
    end else if (accept) begin
      fill_p1      <= fill_nxt;
      win_vld_p1   <= (fill_nxt == FILL_FULL);
      last_mode_p1 <= mode_in;
    end
  end

  assign dout      = taps_p1;
  assign fill_cnt  = fill_p1;
  assign win_valid = win_vld_p1;

endmodule
